param_data_memory: RTL and testbench

PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

---
 rtl/param_data_memory.sv | 137 +++++++++++++
 tb/tb_param_data_memory.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_data_memory.sv
// Word-addressed data memory behind a valid/ready request port with a
// programmable number of wait states and a one-cycle response strobe.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | req_ready=1, waiting for req_valid; request latched on accept
//   WAIT  | wait counter runs down; write commit/read capture on exit
//   RESP  | resp_valid=1 for exactly one cycle, then back to IDLE
//
// Every request spends at least one cycle in WAIT, including with
// WAIT_STATES=0. This keeps the response WAIT_STATES+1 edges after the
// accept edge for every setting. It also means the commit and capture
// always work from the latched request and never from the live inputs.
module param_data_memory #(
   parameter int          DATA_W      = 32,
   parameter int          DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
   parameter int          WAIT_STATES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [31:0]           req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  resp_err
);

   localparam int NBE = DATA_W / 8;
   localparam int LSB = $clog2(NBE);
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic              lat_write;
   logic [31:0]       lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [NBE-1:0]    lat_be;

   logic [31:0]       offset;
   logic [31:0]       index;
   logic              addr_err;
   logic [DATA_W-1:0] cur_word;
   logic [DATA_W-1:0] new_word;
   logic              commit;

   // Contents are deliberately outside the reset domain.
   logic [DATA_W-1:0] mem [DEPTH];

   // Address decode, error detection and byte-lane merge of the latched request.
   always_comb begin
      offset   = lat_addr - BASE_ADDR;
      index    = offset >> LSB;
      addr_err = (lat_addr < BASE_ADDR) ||
                 (index >= 32'(DEPTH)) ||
                 (lat_addr[LSB-1:0] != '0);
      cur_word = mem[index[AW-1:0]];
      new_word = cur_word;
      if (lat_write) begin
         for (int i = 0; i < NBE; i++) begin
            if (lat_be[i]) begin
               new_word[8*i +: 8] = lat_wdata[8*i +: 8];
            end
         end
      end
      commit = (state == WAIT) && (cnt == 4'd0);
   end

   // Memory update on the edge that enters RESP; erroring requests never write.
   always_ff @(posedge clk) begin
      if (commit && lat_write && !addr_err) begin
         mem[index[AW-1:0]] <= new_word;
      end
   end

   // Request/response sequencing with registered handshake and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_be     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  lat_be    <= req_be;
                  cnt       <= 4'(WAIT_STATES);
                  req_ready <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  resp_valid <= 1'b1;
                  resp_err   <= addr_err;
                  resp_rdata <= addr_err ? '0 : new_word;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench for param_data_memory: a default 32-bit instance with three
// wait states and a 64-bit instance with no wait states, sharing clk and rst.
module tb_param_data_memory;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        n_req_valid, n_req_ready, n_req_write;
   logic [31:0] n_req_addr, n_req_wdata;
   logic [3:0]  n_req_be;
   logic        n_resp_valid, n_resp_err;
   logic [31:0] n_resp_rdata;

   logic        w_req_valid, w_req_ready, w_req_write;
   logic [31:0] w_req_addr;
   logic [63:0] w_req_wdata;
   logic [7:0]  w_req_be;
   logic        w_resp_valid, w_resp_err;
   logic [63:0] w_resp_rdata;

   param_data_memory dut (
      .clk(clk), .rst(rst),
      .req_valid(n_req_valid), .req_ready(n_req_ready), .req_write(n_req_write),
      .req_addr(n_req_addr), .req_wdata(n_req_wdata), .req_be(n_req_be),
      .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_err(n_resp_err)
   );

   param_data_memory #(.DATA_W(64), .WAIT_STATES(0)) dut64 (
      .clk(clk), .rst(rst),
      .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(w_req_write),
      .req_addr(w_req_addr), .req_wdata(w_req_wdata), .req_be(w_req_be),
      .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata), .resp_err(w_resp_err)
   );

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input bit wide, output logic v, output logic rdy,
                         output logic er, output logic [63:0] rd);
      v   = wide ? w_resp_valid : n_resp_valid;
      rdy = wide ? w_req_ready  : n_req_ready;
      er  = wide ? w_resp_err   : n_resp_err;
      rd  = wide ? w_resp_rdata : {32'b0, n_resp_rdata};
   endtask

   // Wait (bounded) for the response, pop its expectation and compare.
   task automatic wait_resp(input bit wide, input string tag);
      exp_t        e;
      bit          seen = 1'b0;
      bit          busy_ok = 1'b1;
      int          lat = -1;
      logic        v, rdy, er;
      logic [63:0] rd;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         sample(wide, v, rdy, er, rd);
         if (rdy !== 1'b0) busy_ok = 1'b0;
         if (v === 1'b1) begin
            seen = 1'b1;
            lat  = k - 1;
            break;
         end
      end
      check({tag, "_seen"}, 64'(seen), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (seen) begin
            check({tag, "_rdata"}, rd, e.rdata);
            check({tag, "_err"}, 64'(er), 64'(e.err));
            check({tag, "_latency"}, 64'(lat), 64'(e.lat));
         end
      end
      check({tag, "_ready_low"}, 64'(busy_ok), 64'd1);
      @(negedge clk);
      sample(wide, v, rdy, er, rd);
      check({tag, "_idle_flags"}, {61'b0, v, er, rdy}, 64'b001);
      check({tag, "_idle_rdata"}, rd, 64'd0);
   endtask

   // Present one request in IDLE, push its expectation, then check the response.
   task automatic txn(input bit wide, input logic wr, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [7:0] be,
                      input logic [63:0] exp_rd, input logic exp_err, input string tag);
      exp_t e;
      @(negedge clk);
      e.rdata = exp_rd;
      e.err   = exp_err;
      if (wide) begin
         w_req_valid = 1'b1; w_req_write = wr; w_req_addr = addr;
         w_req_wdata = wd;   w_req_be = be;
         check({tag, "_ready"}, 64'(w_req_ready), 64'd1);
         e.lat = 1;
      end else begin
         n_req_valid = 1'b1; n_req_write = wr; n_req_addr = addr;
         n_req_wdata = wd[31:0]; n_req_be = be[3:0];
         check({tag, "_ready"}, 64'(n_req_ready), 64'd1);
         e.lat = 4;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      n_req_valid = 1'b0;
      w_req_valid = 1'b0;
      wait_resp(wide, tag);
   endtask

   initial begin
      exp_t e;
      int   pulses, first_k, second_k;
      bit   busy_ok;

      rst = 1'b1;
      n_req_valid = 0; n_req_write = 0; n_req_addr = 0; n_req_wdata = 0; n_req_be = 0;
      w_req_valid = 0; w_req_write = 0; w_req_addr = 0; w_req_wdata = 0; w_req_be = 0;
      #1;
      check("reset_n_flags", {61'b0, n_req_ready, n_resp_valid, n_resp_err}, 64'b100);
      check("reset_n_rdata", {32'b0, n_resp_rdata}, 64'd0);
      check("reset_w_flags", {61'b0, w_req_ready, w_resp_valid, w_resp_err}, 64'b100);
      check("reset_w_rdata", w_resp_rdata, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      txn(0, 1, 32'h400, 64'hDEADBEEF, 8'hF, 64'hDEADBEEF, 0, "wr_400");
      txn(0, 0, 32'h400, 64'h0,        8'hF, 64'hDEADBEEF, 0, "rd_400");
      txn(0, 1, 32'h408, 64'h11223344, 8'hF, 64'h11223344, 0, "wr_408");
      txn(0, 1, 32'h408, 64'h000000AA, 8'h1, 64'h112233AA, 0, "wr_408_lane0");
      txn(0, 0, 32'h408, 64'h0,        8'hF, 64'h112233AA, 0, "rd_408");
      txn(0, 0, 32'h3FC, 64'h0,        8'hF, 64'h0,        1, "rd_below_base");
      txn(0, 0, 32'h1400, 64'h0,       8'hF, 64'h0,        1, "rd_past_end");
      txn(0, 0, 32'h402, 64'h0,        8'hF, 64'h0,        1, "rd_misaligned");
      txn(0, 1, 32'h1400, 64'h12345678, 8'hF, 64'h0,       1, "wr_past_end");
      txn(0, 1, 32'h401, 64'h55555555, 8'hF, 64'h0,        1, "wr_misaligned");
      txn(0, 1, 32'h400, 64'hFFFFFFFF, 8'h0, 64'hDEADBEEF, 0, "wr_be_zero");
      txn(0, 0, 32'h400, 64'h0,        8'hF, 64'hDEADBEEF, 0, "rd_400_unchanged");
      txn(0, 1, 32'h13FC, 64'hCAFEF00D, 8'hF, 64'hCAFEF00D, 0, "wr_last");
      txn(0, 0, 32'h13FC, 64'h0,       8'hF, 64'hCAFEF00D, 0, "rd_last");

      // Back-to-back reads with req_valid held high across the handshake.
      e.err = 0; e.lat = 4;
      e.rdata = 64'hDEADBEEF; sb.push_back(e);
      e.rdata = 64'h112233AA; sb.push_back(e);
      @(negedge clk);
      n_req_valid = 1'b1; n_req_write = 1'b0; n_req_addr = 32'h400; n_req_be = 4'hF;
      check("b2b_ready_first", 64'(n_req_ready), 64'd1);
      @(posedge clk);
      pulses = 0; first_k = 0; second_k = 0; busy_ok = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 6) begin
            check("b2b_ready_idle", 64'(n_req_ready), 64'd1);
            n_req_addr = 32'h408;
         end else if (k <= 11 && n_req_ready !== 1'b0) begin
            busy_ok = 1'b0;
         end
         if (k == 7) n_req_valid = 1'b0;
         if (n_resp_valid === 1'b1) begin
            pulses++;
            if (pulses == 1) first_k = k;
            if (pulses == 2) second_k = k;
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("b2b_rdata", {32'b0, n_resp_rdata}, e.rdata);
               check("b2b_err", 64'(n_resp_err), 64'(e.err));
            end
         end
      end
      check("b2b_pulses", 64'(pulses), 64'd2);
      check("b2b_first_at", 64'(first_k), 64'd5);
      check("b2b_second_at", 64'(second_k), 64'd11);
      check("b2b_ready_low", 64'(busy_ok), 64'd1);

      // Reset during the second WAIT cycle of a write drops the write.
      txn(0, 1, 32'h404, 64'h5, 8'hF, 64'h5, 0, "wr_404");
      @(negedge clk);
      n_req_valid = 1'b1; n_req_write = 1'b1; n_req_addr = 32'h404;
      n_req_wdata = 32'h9; n_req_be = 4'hF;
      @(posedge clk);
      #1;
      n_req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_async_flags", {61'b0, n_req_ready, n_resp_valid, n_resp_err}, 64'b100);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (n_resp_valid === 1'b1) pulses++;
      end
      check("rst_no_resp", 64'(pulses), 64'd0);
      txn(0, 0, 32'h404, 64'h0, 8'hF, 64'h5, 0, "rd_404_after_rst");

      // 64-bit, zero-wait-state instance.
      txn(1, 1, 32'h408, 64'h0123456789ABCDEF, 8'hFF, 64'h0123456789ABCDEF, 0, "w_wr_408");
      txn(1, 0, 32'h408, 64'h0, 8'hFF, 64'h0123456789ABCDEF, 0, "w_rd_408");
      txn(1, 1, 32'h408, 64'hFFFFFFFFFFFFFFFF, 8'h80, 64'hFF23456789ABCDEF, 0, "w_wr_lane7");
      txn(1, 0, 32'h404, 64'h0, 8'hFF, 64'h0, 1, "w_rd_misaligned");
      txn(1, 0, 32'h408, 64'h0, 8'hFF, 64'hFF23456789ABCDEF, 0, "w_rd_408_again");

      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
